// File: rtl/fixed_divider_seq.sv
// rtl/fixed_divider_seq.sv - sequential restoring fixed-point divider, Q(SIZE).(FRAC) result
module fixed_divider_seq #(
    parameter int SIZE = 8,
    parameter int FRAC = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic            sgn,
    input  logic            rnd,
    output logic [SIZE-1:0] m,
    output logic [FRAC-1:0] f,
    output logic            busy,
    output logic            done,
    output logic            div_zero,
    output logic            overflow
);

    // W result bits, N quotient bits including the rounding guard bit
    localparam int W  = SIZE + FRAC;
    localparam int N  = W + 1;
    localparam int CW = $clog2(N + 1);

    // Saturation values and rounded-magnitude limits for the signed range
    localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};
    localparam logic [W:0]   POS_LIM = {2'b00, {(W-1){1'b1}}};
    localparam logic [W:0]   NEG_LIM = {2'b01, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PREP = 2'd1,
        S_DIV  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Captured operands and mode bits
    logic [SIZE-1:0] a_q, a_d;
    logic [SIZE-1:0] b_q, b_d;
    logic            sgn_q, sgn_d;
    logic            rnd_q, rnd_d;

    // Division datapath
    logic [SIZE-1:0] mag_b_q, mag_b_d;
    logic [N-1:0]    dvd_q, dvd_d;
    logic [N-1:0]    quo_q, quo_d;
    logic [SIZE:0]   rem_q, rem_d;
    logic            neg_q, neg_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    // Registered results
    logic [W-1:0]    res_q, res_d;
    logic            dz_q, dz_d;
    logic            ov_q, ov_d;
    logic            done_q, done_d;

    // Combinational helpers
    logic [SIZE-1:0] mag_a;
    logic [SIZE-1:0] mag_b;
    logic [SIZE+1:0] trial;
    logic            ge;
    logic [W-1:0]    q_mag;
    logic            guard;
    logic [W:0]      r_sum;
    logic [W-1:0]    fin_res;
    logic            fin_dz;
    logic            fin_ov;

    assign mag_a = (sgn_q && a_q[SIZE-1]) ? (~a_q + SIZE'(1)) : a_q;
    assign mag_b = (sgn_q && b_q[SIZE-1]) ? (~b_q + SIZE'(1)) : b_q;

    // One restoring step: shift next dividend bit into the remainder, subtract if it fits
    assign trial = {rem_q, dvd_q[N-1]};
    assign ge    = (trial >= {2'b00, mag_b_q});

    // Quotient magnitude, guard bit and the rounded magnitude (one bit wider for the carry)
    assign q_mag = quo_q[N-1:1];
    assign guard = quo_q[0];
    assign r_sum = {1'b0, q_mag} + {{W{1'b0}}, rnd_q & guard};

    // Final result selection: divide-by-zero, saturation or the (negated) rounded magnitude
    always_comb begin
        fin_res = r_sum[W-1:0];
        fin_dz  = 1'b0;
        fin_ov  = 1'b0;
        if (mag_b_q == '0) begin
            fin_dz = 1'b1;
            if (!sgn_q) begin
                fin_res = '1;
            end else if (a_q[SIZE-1]) begin
                fin_res = MIN_NEG;
            end else begin
                fin_res = MAX_POS;
            end
        end else if (!sgn_q) begin
            if (r_sum[W]) begin
                fin_res = '1;
                fin_ov  = 1'b1;
            end
        end else if (!neg_q) begin
            if (r_sum > POS_LIM) begin
                fin_res = MAX_POS;
                fin_ov  = 1'b1;
            end
        end else begin
            if (r_sum > NEG_LIM) begin
                fin_res = MIN_NEG;
                fin_ov  = 1'b1;
            end else begin
                fin_res = ~r_sum[W-1:0] + W'(1);
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_PREP;
            S_PREP: state_d = (b_q == '0) ? S_FIN : S_DIV;
            S_DIV:  if (cnt_q == CW'(1)) state_d = S_FIN;
            S_FIN:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        busy = (state_q != S_IDLE);
    end

    // Datapath next-state: capture, prepare magnitudes, iterate, register results
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        rnd_d   = rnd_q;
        mag_b_d = mag_b_q;
        dvd_d   = dvd_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        neg_d   = neg_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        dz_d    = dz_q;
        ov_d    = ov_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d   = a;
                    b_d   = b;
                    sgn_d = sgn;
                    rnd_d = rnd;
                end
            end
            S_PREP: begin
                mag_b_d = mag_b;
                dvd_d   = {mag_a, {(FRAC+1){1'b0}}};
                quo_d   = '0;
                rem_d   = '0;
                neg_d   = sgn_q & (a_q[SIZE-1] ^ b_q[SIZE-1]);
                cnt_d   = CW'(N);
            end
            S_DIV: begin
                rem_d = ge ? (trial[SIZE:0] - {1'b0, mag_b_q}) : trial[SIZE:0];
                quo_d = {quo_q[N-2:0], ge};
                dvd_d = {dvd_q[N-2:0], 1'b0};
                cnt_d = cnt_q - CW'(1);
            end
            S_FIN: begin
                res_d  = fin_res;
                dz_d   = fin_dz;
                ov_d   = fin_ov;
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath registers; reset abandons any operation and clears the outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            rnd_q   <= 1'b0;
            mag_b_q <= '0;
            dvd_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            dz_q    <= 1'b0;
            ov_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            rnd_q   <= rnd_d;
            mag_b_q <= mag_b_d;
            dvd_q   <= dvd_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            neg_q   <= neg_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            dz_q    <= dz_d;
            ov_q    <= ov_d;
            done_q  <= done_d;
        end
    end

    assign m        = res_q[W-1:FRAC];
    assign f        = res_q[FRAC-1:0];
    assign done     = done_q;
    assign div_zero = dz_q;
    assign overflow = ov_q;

endmodule

// File: tb/tb_fixed_divider_seq.sv
// tb/tb_fixed_divider_seq.sv - self-checking bench for fixed_divider_seq
module tb_fixed_divider_seq;

    localparam int SIZE = 8;
    localparam int FRAC = 10;
    localparam int W    = SIZE + FRAC;
    localparam int LAT  = SIZE + FRAC + 3;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic [SIZE-1:0] a = '0;
    logic [SIZE-1:0] b = '0;
    logic            sgn = 1'b0;
    logic            rnd = 1'b0;
    logic [SIZE-1:0] m;
    logic [FRAC-1:0] f;
    logic            busy;
    logic            done;
    logic            div_zero;
    logic            overflow;

    int checks   = 0;
    int failures = 0;

    fixed_divider_seq #(.SIZE(SIZE), .FRAC(FRAC)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .sgn(sgn), .rnd(rnd),
        .m(m), .f(f), .busy(busy), .done(done), .div_zero(div_zero), .overflow(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sgn;
        logic       rnd;
        logic [7:0] m;
        logic [9:0] f;
        logic       dz;
        logic       ov;
        int         lat;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: exact rational arithmetic on magnitudes, then range rules
    task automatic model(input logic [7:0] ia, input logic [7:0] ib, input logic isgn,
                         input logic irnd, output logic [17:0] res, output logic dz,
                         output logic ov);
        longint av, bv, ma, mb, q, r;
        bit neg;
        av = isgn ? longint'($signed(ia)) : longint'(ia);
        bv = isgn ? longint'($signed(ib)) : longint'(ib);
        dz = 1'b0;
        ov = 1'b0;
        if (bv == 0) begin
            dz = 1'b1;
            if (!isgn) res = 18'h3FFFF;
            else       res = (av < 0) ? 18'h20000 : 18'h1FFFF;
        end else begin
            neg = isgn && ((av < 0) != (bv < 0));
            ma = (av < 0) ? -av : av;
            mb = (bv < 0) ? -bv : bv;
            q = (ma * 1024) / mb;
            r = (ma * 1024) % mb;
            if (irnd && (2 * r >= mb)) q = q + 1;
            if (!isgn) begin
                if (q >= 262144) begin res = 18'h3FFFF; ov = 1'b1; end
                else res = q[17:0];
            end else if (!neg) begin
                if (q > 131071) begin res = 18'h1FFFF; ov = 1'b1; end
                else res = q[17:0];
            end else begin
                if (q > 131072) begin res = 18'h20000; ov = 1'b1; end
                else begin q = -q; res = q[17:0]; end
            end
        end
    endtask

    // Issue one start pulse and wait (bounded) for done; lat counts edges after the sampling edge
    task automatic do_op(input logic [7:0] ia, input logic [7:0] ib, input logic isgn,
                         input logic irnd, output int lat, output logic [7:0] om,
                         output logic [9:0] of, output logic odz, output logic oov);
        @(negedge clk);
        a = ia; b = ib; sgn = isgn; rnd = irnd; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); sgn = 1'($urandom); rnd = 1'($urandom);
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) break;
        end
        om = m; of = f; odz = div_zero; oov = overflow;
    endtask

    int         lat;
    logic [7:0] rm;
    logic [9:0] rf;
    logic       rdz, rov;
    logic [17:0] eres;
    logic       edz, eov;
    logic [7:0] ra, rb;
    logic       rs, rr;
    int         dcnt, first_done, elat;
    logic       busy_ok;
    logic [7:0] hm;
    logic [9:0] hf;

    initial begin
        vecs[0]  = '{8'd1,   8'd3,   1'b0, 1'b0, 8'h00, 10'h155, 1'b0, 1'b0, LAT};
        vecs[1]  = '{8'd2,   8'd3,   1'b0, 1'b0, 8'h00, 10'h2AA, 1'b0, 1'b0, LAT};
        vecs[2]  = '{8'd2,   8'd3,   1'b0, 1'b1, 8'h00, 10'h2AB, 1'b0, 1'b0, LAT};
        vecs[3]  = '{8'd10,  8'd3,   1'b0, 1'b0, 8'h03, 10'h155, 1'b0, 1'b0, LAT};
        vecs[4]  = '{8'd0,   8'd3,   1'b0, 1'b0, 8'h00, 10'h000, 1'b0, 1'b0, LAT};
        vecs[5]  = '{8'd15,  8'd0,   1'b0, 1'b0, 8'hFF, 10'h3FF, 1'b1, 1'b0, 2};
        vecs[6]  = '{8'hF0,  8'd0,   1'b1, 1'b0, 8'h80, 10'h000, 1'b1, 1'b0, 2};
        vecs[7]  = '{8'hF9,  8'h02,  1'b1, 1'b0, 8'hFC, 10'h200, 1'b0, 1'b0, LAT};
        vecs[8]  = '{8'h80,  8'hFF,  1'b1, 1'b0, 8'h7F, 10'h3FF, 1'b0, 1'b1, LAT};
        vecs[9]  = '{8'h80,  8'h01,  1'b1, 1'b0, 8'h80, 10'h000, 1'b0, 1'b0, LAT};
        vecs[10] = '{8'h7F,  8'h01,  1'b1, 1'b1, 8'h7F, 10'h000, 1'b0, 1'b0, LAT};
        vecs[11] = '{8'hFE,  8'h03,  1'b1, 1'b1, 8'hFF, 10'h155, 1'b0, 1'b0, LAT};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_m", m, 0);
        chk("rst_f", f, 0);
        chk("rst_dz", div_zero, 0);
        chk("rst_ov", overflow, 0);
        @(negedge clk);
        rst = 1'b1;

        // Directed table
        for (int i = 0; i < 12; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].rnd, lat, rm, rf, rdz, rov);
            chk($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
            chk($sformatf("vec%0d_m", i), rm, vecs[i].m);
            chk($sformatf("vec%0d_f", i), rf, vecs[i].f);
            chk($sformatf("vec%0d_dz", i), rdz, vecs[i].dz);
            chk($sformatf("vec%0d_ov", i), rov, vecs[i].ov);
        end

        // Start while busy is ignored: one done, result of the first operation
        @(negedge clk);
        a = 8'd1; b = 8'd3; sgn = 1'b0; rnd = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dcnt = 0; first_done = 0; busy_ok = 1'b1; hm = '0; hf = '0;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk);
            #1;
            if (c < LAT && !busy) busy_ok = 1'b0;
            if (done) begin
                dcnt++;
                if (first_done == 0) first_done = c;
                hm = m; hf = f;
            end
            if (c == 5) begin
                a = 8'd200; b = 8'd7; start = 1'b1;
            end else if (c == 6) begin
                start = 1'b0;
            end
        end
        chk("busy_held", busy_ok, 1);
        chk("single_done", dcnt, 1);
        chk("ignored_lat", first_done, LAT);
        chk("ignored_m", hm, 8'h00);
        chk("ignored_f", hf, 10'h155);

        // Start in the done cycle is accepted
        do_op(8'd2, 8'd3, 1'b0, 1'b1, lat, rm, rf, rdz, rov);
        chk("pre_done", done, 1);
        a = 8'd10; b = 8'd3; sgn = 1'b0; rnd = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("accept_busy", busy, 1);
        chk("accept_done_low", done, 0);
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) break;
        end
        chk("accept_lat", lat, LAT);
        chk("accept_m", m, 8'h03);
        chk("accept_f", f, 10'h155);

        // Reset mid-operation
        @(negedge clk);
        a = 8'd100; b = 8'd7; sgn = 1'b0; rnd = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_m", m, 0);
        chk("mid_rst_f", f, 0);
        chk("mid_rst_dz", div_zero, 0);
        chk("mid_rst_ov", overflow, 0);
        @(negedge clk);
        rst = 1'b1;
        do_op(8'd9, 8'd3, 1'b0, 1'b0, lat, rm, rf, rdz, rov);
        chk("post_rst_lat", lat, LAT);
        chk("post_rst_m", rm, 8'h03);
        chk("post_rst_f", rf, 10'h000);

        // Randomized against the reference model
        for (int i = 0; i < 200; i++) begin
            ra = 8'($urandom);
            rb = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
            if (i % 7 == 0) rb = 8'hFF;
            rs = 1'($urandom);
            rr = 1'($urandom);
            model(ra, rb, rs, rr, eres, edz, eov);
            elat = (rb == 8'd0) ? 2 : LAT;
            do_op(ra, rb, rs, rr, lat, rm, rf, rdz, rov);
            chk($sformatf("rand%0d_lat a=%0h b=%0h s=%0b r=%0b", i, ra, rb, rs, rr), lat, elat);
            chk($sformatf("rand%0d_mf a=%0h b=%0h s=%0b r=%0b", i, ra, rb, rs, rr), {rm, rf}, eres);
            chk($sformatf("rand%0d_dz", i), rdz, edz);
            chk($sformatf("rand%0d_ov", i), rov, eov);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
